// File: rtl/wrd_cfg_ctrl_pkg.sv
// Shared types and default widths for the word-recognition config/inference sequencer.
// Targets are indexed by the upper bank bits: conv1, conv2, fc.
package wrd_cfg_ctrl_pkg;

    localparam int VECTOR_BW_DEF = 104;
    localparam int ADDR_BW_DEF   = 6;
    localparam int TGT_BW_DEF    = 2;
    localparam int LBANK_BW_DEF  = 5;
    localparam int NUM_TGT_DEF   = 3;
    localparam int RD_LAT_DEF    = 1;

    localparam int TGT_CONV1 = 0;
    localparam int TGT_CONV2 = 1;
    localparam int TGT_FC    = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_RUN,
        ST_DRAIN
    } state_e;

    // Width of a down-counter that must hold the value lat.
    function automatic int cnt_bw(input int lat);
        return (lat < 1) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/wrd_cfg_ctrl_if.sv
// Host configuration port: request side driven by the host (master),
// ready/read-data/error returned by the sequencer (slave).
interface wrd_cfg_ctrl_if
    import wrd_cfg_ctrl_pkg::*;
#(
    parameter int VECTOR_BW = VECTOR_BW_DEF,
    parameter int ADDR_BW   = ADDR_BW_DEF,
    parameter int TGT_BW    = TGT_BW_DEF,
    parameter int LBANK_BW  = LBANK_BW_DEF
) ();

    logic                       rd_en;
    logic                       wr_en;
    logic [TGT_BW+LBANK_BW-1:0] bank;
    logic [ADDR_BW-1:0]         addr;
    logic [VECTOR_BW-1:0]       wr_data;
    logic                       ready;
    logic [VECTOR_BW-1:0]       rd_data;
    logic                       rd_valid;
    logic                       err;

    modport master (
        output rd_en, wr_en, bank, addr, wr_data,
        input  ready, rd_data, rd_valid, err
    );

    modport slave (
        input  rd_en, wr_en, bank, addr, wr_data,
        output ready, rd_data, rd_valid, err
    );

endinterface

// File: rtl/wrd_cfg_ctrl_decode.sv
// Splits a host bank into {target select, local bank} and produces a one-hot
// target select that is all-zero for an out-of-range target.
module wrd_cfg_ctrl_decode
    import wrd_cfg_ctrl_pkg::*;
#(
    parameter int TGT_BW   = TGT_BW_DEF,
    parameter int LBANK_BW = LBANK_BW_DEF,
    parameter int NUM_TGT  = NUM_TGT_DEF
) (
    input  logic [TGT_BW+LBANK_BW-1:0] bank_i,
    output logic [TGT_BW-1:0]          tgt_o,
    output logic [LBANK_BW-1:0]        lbank_o,
    output logic                       tgt_ok_o,
    output logic [NUM_TGT-1:0]         onehot_o
);

    assign {tgt_o, lbank_o} = bank_i;
    assign tgt_ok_o = (int'(tgt_o) < NUM_TGT);

    for (genvar k = 0; k < NUM_TGT; k++) begin : g_oh
        assign onehot_o[k] = (tgt_o == TGT_BW'(k));
    end

endmodule

// File: rtl/wrd_cfg_ctrl.sv
// Config/inference sequencer: decodes host memory requests into per-layer
// requests and holds the input stream off while the layer memories are touched.
module wrd_cfg_ctrl
    import wrd_cfg_ctrl_pkg::*;
#(
    parameter int VECTOR_BW = VECTOR_BW_DEF,
    parameter int ADDR_BW   = ADDR_BW_DEF,
    parameter int TGT_BW    = TGT_BW_DEF,
    parameter int LBANK_BW  = LBANK_BW_DEF,
    parameter int NUM_TGT   = NUM_TGT_DEF,
    parameter int RD_LAT    = RD_LAT_DEF
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    wrd_cfg_ctrl_if.slave                cfg,
    output logic [NUM_TGT-1:0]           tgt_rd_en_o,
    output logic [NUM_TGT-1:0]           tgt_wr_en_o,
    output logic [LBANK_BW-1:0]          tgt_bank_o,
    output logic [ADDR_BW-1:0]           tgt_addr_o,
    output logic [VECTOR_BW-1:0]         tgt_wr_data_o,
    input  logic [NUM_TGT*VECTOR_BW-1:0] tgt_rd_data_i,
    input  logic                         s_valid_i,
    input  logic                         s_last_i,
    output logic                         s_ready_o,
    output logic                         m_valid_o,
    output logic                         m_last_o,
    input  logic                         m_ready_i,
    input  logic                         done_i,
    output logic                         busy_o
);

    localparam int CNT_BW = cnt_bw(RD_LAT);

    state_e                state_q, state_d;
    logic [CNT_BW-1:0]     cnt_q, cnt_d;
    logic [TGT_BW-1:0]     sel_q, sel_d;
    logic                  sel_ok_q, sel_ok_d;
    logic [NUM_TGT-1:0]    rd_en_q, rd_en_d;
    logic [NUM_TGT-1:0]    wr_en_q, wr_en_d;
    logic [LBANK_BW-1:0]   bank_q, bank_d;
    logic [ADDR_BW-1:0]    addr_q, addr_d;
    logic [VECTOR_BW-1:0]  wdata_q, wdata_d;
    logic [VECTOR_BW-1:0]  rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  err_q, err_d;

    logic [TGT_BW-1:0]     dec_tgt;
    logic [LBANK_BW-1:0]   dec_lbank;
    logic                  dec_ok;
    logic [NUM_TGT-1:0]    dec_oh;

    logic                  cfg_req;
    logic                  gate;
    logic                  hs;

    logic [NUM_TGT-1:0][VECTOR_BW-1:0] rd_slices;
    logic [VECTOR_BW-1:0]              rd_sel;

    wrd_cfg_ctrl_decode #(
        .TGT_BW   (TGT_BW),
        .LBANK_BW (LBANK_BW),
        .NUM_TGT  (NUM_TGT)
    ) u_decode (
        .bank_i   (cfg.bank),
        .tgt_o    (dec_tgt),
        .lbank_o  (dec_lbank),
        .tgt_ok_o (dec_ok),
        .onehot_o (dec_oh)
    );

    // Stream passes only when memories cannot change underneath a frame.
    always_comb begin
        cfg_req   = cfg.rd_en | cfg.wr_en;
        gate      = ((state_q == ST_IDLE) && !cfg_req) || (state_q == ST_RUN);
        s_ready_o = m_ready_i & gate;
        m_valid_o = s_valid_i & gate;
        m_last_o  = s_last_i;
        hs        = s_valid_i & s_ready_o;
    end

    assign rd_slices = tgt_rd_data_i;

    // Out-of-range targets read back as zero.
    always_comb begin
        rd_sel = '0;
        for (int k = 0; k < NUM_TGT; k++) begin
            if (sel_ok_q && (sel_q == TGT_BW'(k))) rd_sel = rd_slices[k];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        sel_ok_d = sel_ok_q;
        rd_en_d  = '0;
        wr_en_d  = '0;
        bank_d   = bank_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                err_d = done_i;
                if (cfg.rd_en && cfg.wr_en) begin
                    err_d = 1'b1;
                end else if (cfg.wr_en) begin
                    state_d = ST_WR;
                    wr_en_d = dec_oh;
                    bank_d  = dec_lbank;
                    addr_d  = cfg.addr;
                    wdata_d = cfg.wr_data;
                    err_d   = done_i | ~dec_ok;
                end else if (cfg.rd_en) begin
                    state_d  = ST_RD;
                    rd_en_d  = dec_oh;
                    bank_d   = dec_lbank;
                    addr_d   = cfg.addr;
                    sel_d    = dec_tgt;
                    sel_ok_d = dec_ok;
                    cnt_d    = CNT_BW'(RD_LAT);
                    err_d    = done_i | ~dec_ok;
                end else if (hs) begin
                    state_d = s_last_i ? ST_DRAIN : ST_RUN;
                end
            end
            ST_WR: begin
                err_d   = done_i;
                state_d = ST_IDLE;
            end
            ST_RD: begin
                err_d = done_i;
                if (cnt_q == '0) begin
                    rdata_d  = rd_sel;
                    rvalid_d = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RUN: begin
                err_d = done_i;
                if (hs && s_last_i) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (done_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sel_q    <= '0;
            sel_ok_q <= 1'b0;
            rd_en_q  <= '0;
            wr_en_q  <= '0;
            bank_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            sel_ok_q <= sel_ok_d;
            rd_en_q  <= rd_en_d;
            wr_en_q  <= wr_en_d;
            bank_q   <= bank_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    assign cfg.ready     = (state_q == ST_IDLE);
    assign cfg.rd_data   = rdata_q;
    assign cfg.rd_valid  = rvalid_q;
    assign cfg.err       = err_q;
    assign tgt_rd_en_o   = rd_en_q;
    assign tgt_wr_en_o   = wr_en_q;
    assign tgt_bank_o    = bank_q;
    assign tgt_addr_o    = addr_q;
    assign tgt_wr_data_o = wdata_q;
    assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_wrd_cfg_ctrl.sv
// Bench for wrd_cfg_ctrl: target memory stubs behind two instances (read latency 1 and 3),
// host/stream stimulus, expectations from a memory model and the protocol timing rules.
module tb_wrd_cfg_ctrl;
    import wrd_cfg_ctrl_pkg::*;

    localparam int VBW = 104;
    localparam int ABW = 6;
    localparam int TBW = 2;
    localparam int LBW = 5;
    localparam int NT  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    wrd_cfg_ctrl_if #(.VECTOR_BW(VBW), .ADDR_BW(ABW), .TGT_BW(TBW), .LBANK_BW(LBW)) cif ();
    wrd_cfg_ctrl_if #(.VECTOR_BW(VBW), .ADDR_BW(ABW), .TGT_BW(TBW), .LBANK_BW(LBW)) cif3 ();

    logic [NT-1:0]     tgt_rd_en, tgt_wr_en, t3_rd_en, t3_wr_en;
    logic [LBW-1:0]    tgt_bank, t3_bank;
    logic [ABW-1:0]    tgt_addr, t3_addr;
    logic [VBW-1:0]    tgt_wdata, t3_wdata;
    logic [NT*VBW-1:0] tgt_rdata, t3_rdata;
    logic s_valid, s_last, s_ready, m_valid, m_last, m_ready, done, busy;
    logic t3_s_ready, t3_m_valid, t3_m_last, t3_busy;

    wrd_cfg_ctrl #(.VECTOR_BW(VBW), .ADDR_BW(ABW), .TGT_BW(TBW), .LBANK_BW(LBW),
                   .NUM_TGT(NT), .RD_LAT(1)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .cfg(cif),
        .tgt_rd_en_o(tgt_rd_en), .tgt_wr_en_o(tgt_wr_en), .tgt_bank_o(tgt_bank),
        .tgt_addr_o(tgt_addr), .tgt_wr_data_o(tgt_wdata), .tgt_rd_data_i(tgt_rdata),
        .s_valid_i(s_valid), .s_last_i(s_last), .s_ready_o(s_ready),
        .m_valid_o(m_valid), .m_last_o(m_last), .m_ready_i(m_ready),
        .done_i(done), .busy_o(busy)
    );

    wrd_cfg_ctrl #(.VECTOR_BW(VBW), .ADDR_BW(ABW), .TGT_BW(TBW), .LBANK_BW(LBW),
                   .NUM_TGT(NT), .RD_LAT(3)) dut3 (
        .clk_i(clk), .rst_n_i(rst_n), .cfg(cif3),
        .tgt_rd_en_o(t3_rd_en), .tgt_wr_en_o(t3_wr_en), .tgt_bank_o(t3_bank),
        .tgt_addr_o(t3_addr), .tgt_wr_data_o(t3_wdata), .tgt_rd_data_i(t3_rdata),
        .s_valid_i(1'b0), .s_last_i(1'b0), .s_ready_o(t3_s_ready),
        .m_valid_o(t3_m_valid), .m_last_o(t3_m_last), .m_ready_i(1'b0),
        .done_i(1'b0), .busy_o(t3_busy)
    );

    function automatic int key(input int t, input int b, input int a);
        return t * 4096 + b * 64 + a;
    endfunction

    function automatic logic [VBW-1:0] rnd_vec();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[VBW-1:0];
    endfunction

    function automatic logic [VBW-1:0] pat(input int k, input int b, input int a);
        return {8'hA5, 32'(k * 4096 + b * 64 + a), 32'hC0DE_0000 | 32'(a), 32'(b)};
    endfunction

    // Target memory stub (latency 1): data appears exactly one cycle after the enable.
    logic [VBW-1:0] smem [0:NT*4096-1];
    bit             svld [0:NT*4096-1];
    logic [127:0]   junk;
    int             rd_cyc = -100;
    int             rd_tgt = 0;
    logic [VBW-1:0] rd_val;
    int             t3_cyc = -100;
    int             t3_tgt = 0;
    logic [VBW-1:0] t3_val;

    always @(posedge clk) begin
        junk <= {$urandom, $urandom, $urandom, $urandom};
        for (int k = 0; k < NT; k++) begin
            if (tgt_wr_en[k]) begin
                smem[key(k, int'(tgt_bank), int'(tgt_addr))] <= tgt_wdata;
                svld[key(k, int'(tgt_bank), int'(tgt_addr))] <= 1'b1;
            end
            if (tgt_rd_en[k]) begin
                rd_cyc <= cyc;
                rd_tgt <= k;
                rd_val <= svld[key(k, int'(tgt_bank), int'(tgt_addr))] ?
                          smem[key(k, int'(tgt_bank), int'(tgt_addr))] : '0;
            end
            if (t3_rd_en[k]) begin
                t3_cyc <= cyc;
                t3_tgt <= k;
                t3_val <= pat(k, int'(t3_bank), int'(t3_addr));
            end
        end
    end

    always_comb begin
        tgt_rdata = '0;
        t3_rdata  = '0;
        for (int k = 0; k < NT; k++) begin
            tgt_rdata[k*VBW +: VBW] = (cyc == rd_cyc + 1 && k == rd_tgt) ? rd_val : junk[VBW-1:0];
            t3_rdata[k*VBW +: VBW]  = (cyc == t3_cyc + 3 && k == t3_tgt) ? t3_val : junk[VBW-1:0];
        end
    end

    // Reference memory: what the host has legally written.
    logic [VBW-1:0] exp_mem [int];

    function automatic logic [VBW-1:0] exp_rd(input int t, input int b, input int a);
        if (t >= NT || !exp_mem.exists(key(t, b, a))) return '0;
        return exp_mem[key(t, b, a)];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [1:0] t, input logic [4:0] b, input logic [5:0] a,
                            input logic [VBW-1:0] d);
        cif.wr_en = 1'b1; cif.bank = {t, b}; cif.addr = a; cif.wr_data = d;
        tick();
        cif.wr_en = 1'b0;
        tick();
        if (int'(t) < NT) exp_mem[key(int'(t), int'(b), int'(a))] = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        #1;
        checks++; if (cif.ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b exp 1", cif.ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b exp 0", busy); end
        checks++; if ({tgt_rd_en, tgt_wr_en} !== 6'b0) begin errors++; $display("FAIL reset_en: got %0h exp 0", {tgt_rd_en, tgt_wr_en}); end
        checks++; if ({tgt_bank, tgt_addr} !== 11'b0 || tgt_wdata !== '0) begin errors++; $display("FAIL reset_tgt_bus: bank %0h addr %0h data %0h exp 0", tgt_bank, tgt_addr, tgt_wdata); end
        checks++; if ({cif.rd_valid, cif.err} !== 2'b0 || cif.rd_data !== '0) begin errors++; $display("FAIL reset_cfg_out: valid %0b err %0b data %0h exp 0", cif.rd_valid, cif.err, cif.rd_data); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write();
        logic [VBW-1:0] d;
        d = {13{8'hAB}};
        cif.wr_en = 1'b1; cif.bank = {2'd1, 5'd3}; cif.addr = 6'd5; cif.wr_data = d;
        #1;
        checks++; if (cif.ready !== 1'b1) begin errors++; $display("FAIL wr_ready_T: got %0b exp 1", cif.ready); end
        tick();
        cif.wr_en = 1'b0;
        #1;
        checks++; if (tgt_wr_en !== 3'b010) begin errors++; $display("FAIL wr_en_T1: got %0b exp 010", tgt_wr_en); end
        checks++; if (tgt_bank !== 5'd3 || tgt_addr !== 6'd5 || tgt_wdata !== d) begin errors++; $display("FAIL wr_bus_T1: bank %0d addr %0d data %0h exp 3 5 %0h", tgt_bank, tgt_addr, tgt_wdata, d); end
        checks++; if (cif.ready !== 1'b0) begin errors++; $display("FAIL wr_ready_T1: got %0b exp 0", cif.ready); end
        exp_mem[key(1, 3, 5)] = d;
        tick();
        checks++; if (cif.ready !== 1'b1 || tgt_wr_en !== 3'b0) begin errors++; $display("FAIL wr_T2: ready %0b en %0b exp 1 000", cif.ready, tgt_wr_en); end
    endtask

    task automatic test_read();
        do_write(2'd2, 5'd0, 6'd7, VBW'(16'h1234));
        cif.rd_en = 1'b1; cif.bank = {2'd2, 5'd0}; cif.addr = 6'd7;
        tick();
        cif.rd_en = 1'b0;
        #1;
        checks++; if (tgt_rd_en !== 3'b100) begin errors++; $display("FAIL rd_en_T1: got %0b exp 100", tgt_rd_en); end
        tick();
        checks++; if (cif.rd_valid !== 1'b0 || cif.ready !== 1'b0) begin errors++; $display("FAIL rd_T2: valid %0b ready %0b exp 0 0", cif.rd_valid, cif.ready); end
        tick();
        checks++; if (cif.rd_valid !== 1'b1 || cif.rd_data !== exp_rd(2, 0, 7)) begin errors++; $display("FAIL rd_T3: valid %0b data %0h exp 1 %0h", cif.rd_valid, cif.rd_data, exp_rd(2, 0, 7)); end
        checks++; if (cif.ready !== 1'b1) begin errors++; $display("FAIL rd_ready_T3: got %0b exp 1", cif.ready); end
        tick();
        checks++; if (cif.rd_valid !== 1'b0) begin errors++; $display("FAIL rd_strobe_T4: got %0b exp 0", cif.rd_valid); end
        // Latency-3 instance: valid must land at T+5.
        cif3.rd_en = 1'b1; cif3.bank = {2'd1, 5'd9}; cif3.addr = 6'd33;
        tick();
        cif3.rd_en = 1'b0;
        #1;
        checks++; if (t3_rd_en !== 3'b010) begin errors++; $display("FAIL lat3_en_T1: got %0b exp 010", t3_rd_en); end
        tick(); tick(); tick();
        checks++; if (cif3.rd_valid !== 1'b0 || cif3.ready !== 1'b0) begin errors++; $display("FAIL lat3_T4: valid %0b ready %0b exp 0 0", cif3.rd_valid, cif3.ready); end
        tick();
        checks++; if (cif3.rd_valid !== 1'b1 || cif3.rd_data !== pat(1, 9, 33) || cif3.ready !== 1'b1) begin errors++; $display("FAIL lat3_T5: valid %0b ready %0b data %0h exp 1 1 %0h", cif3.rd_valid, cif3.ready, cif3.rd_data, pat(1, 9, 33)); end
        tick();
    endtask

    task automatic test_random_cfg();
        for (int i = 0; i < 150; i++) begin
            int op, t, b, a;
            bit sv, dn;
            logic [VBW-1:0] d;
            logic [NT-1:0]  oh;
            op = $urandom_range(0, 9); t = $urandom_range(0, 3);
            b = $urandom_range(0, 3);  a = $urandom_range(0, 7);
            d = rnd_vec();
            sv = (op < 9) ? 1'($urandom_range(0, 1)) : 1'b0;
            dn = (op < 8) ? ($urandom_range(0, 3) == 0) : 1'b0;
            oh = (t < NT) ? NT'(1 << t) : '0;
            cif.bank = {2'(t), 5'(b)}; cif.addr = 6'(a); cif.wr_data = d;
            cif.wr_en = (op < 4 || op == 8); cif.rd_en = (op >= 4 && op <= 8);
            done = (op == 9); s_valid = sv; s_last = 1'b0; m_ready = 1'b1;
            #1;
            checks++; if (cif.ready !== 1'b1 || (op < 9 && {s_ready, m_valid} !== 2'b00)) begin errors++; $display("FAIL rnd_accept[%0d] op %0d: ready %0b s_ready %0b m_valid %0b", i, op, cif.ready, s_ready, m_valid); end
            tick();
            cif.wr_en = 1'b0; cif.rd_en = 1'b0; s_valid = 1'b0; done = dn;
            #1;
            if (op < 4) begin
                checks++; if (tgt_wr_en !== oh || cif.err !== (t >= NT) || cif.ready !== 1'b0) begin errors++; $display("FAIL rnd_wr_T1[%0d]: en %0b err %0b ready %0b exp %0b %0b 0", i, tgt_wr_en, cif.err, cif.ready, oh, t >= NT); end
                checks++; if (tgt_bank !== 5'(b) || tgt_addr !== 6'(a) || tgt_wdata !== d) begin errors++; $display("FAIL rnd_wr_bus[%0d]: bank %0d addr %0d exp %0d %0d", i, tgt_bank, tgt_addr, b, a); end
                if (t < NT) exp_mem[key(t, b, a)] = d;
                tick();
                done = 1'b0;
                checks++; if (cif.ready !== 1'b1 || cif.err !== dn || tgt_wr_en !== '0) begin errors++; $display("FAIL rnd_wr_T2[%0d]: ready %0b err %0b en %0b exp 1 %0b 0", i, cif.ready, cif.err, tgt_wr_en, dn); end
            end else if (op < 8) begin
                checks++; if (tgt_rd_en !== oh || cif.err !== (t >= NT) || cif.ready !== 1'b0) begin errors++; $display("FAIL rnd_rd_T1[%0d]: en %0b err %0b ready %0b exp %0b %0b 0", i, tgt_rd_en, cif.err, cif.ready, oh, t >= NT); end
                tick();
                done = 1'b0;
                checks++; if (cif.rd_valid !== 1'b0 || cif.err !== dn || tgt_rd_en !== '0) begin errors++; $display("FAIL rnd_rd_T2[%0d]: valid %0b err %0b en %0b exp 0 %0b 0", i, cif.rd_valid, cif.err, tgt_rd_en, dn); end
                tick();
                checks++; if (cif.rd_valid !== 1'b1 || cif.rd_data !== exp_rd(t, b, a) || cif.ready !== 1'b1) begin errors++; $display("FAIL rnd_rd_T3[%0d]: valid %0b ready %0b data %0h exp 1 1 %0h", i, cif.rd_valid, cif.ready, cif.rd_data, exp_rd(t, b, a)); end
            end else if (op == 8) begin
                checks++; if (cif.err !== 1'b1 || {tgt_rd_en, tgt_wr_en} !== '0 || cif.ready !== 1'b1) begin errors++; $display("FAIL rnd_both[%0d]: err %0b en %0h ready %0b exp 1 0 1", i, cif.err, {tgt_rd_en, tgt_wr_en}, cif.ready); end
            end else begin
                checks++; if (cif.err !== 1'b1 || busy !== 1'b0 || cif.ready !== 1'b1) begin errors++; $display("FAIL rnd_done_idle[%0d]: err %0b busy %0b ready %0b exp 1 0 1", i, cif.err, busy, cif.ready); end
            end
            done = 1'b0;
            tick();
        end
    endtask

    task automatic test_stream();
        int beats = 0;
        int guard = 0;
        bit sv, mr;
        logic [VBW-1:0] d;
        d = rnd_vec();
        cif.bank = {2'd0, 5'd2}; cif.addr = 6'd9; cif.wr_data = d;
        while (beats < 50 && guard < 1000) begin
            sv = ($urandom_range(0, 3) != 0); mr = ($urandom_range(0, 3) != 0);
            s_valid = sv; m_ready = mr; s_last = (beats == 49);
            cif.wr_en = (beats >= 10);
            #1;
            checks++; if ({s_ready, m_valid, m_last, cif.ready, busy} !== {mr, sv, beats == 49, beats == 0, beats > 0}) begin errors++; $display("FAIL stream_beat%0d: got %05b exp %05b", beats, {s_ready, m_valid, m_last, cif.ready, busy}, {mr, sv, beats == 49, beats == 0, beats > 0}); end
            if (sv && mr) beats++;
            guard++;
            tick();
        end
        checks++; if (beats != 50) begin errors++; $display("FAIL stream_timeout: beats %0d exp 50", beats); end
        s_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1; m_ready = 1'b1;
            #1;
            checks++; if ({s_ready, m_valid, cif.ready, busy} !== 4'b0001) begin errors++; $display("FAIL drain_hold%0d: got %04b exp 0001", i, {s_ready, m_valid, cif.ready, busy}); end
            tick();
        end
        s_valid = 1'b0; done = 1'b1;
        tick();
        done = 1'b0;
        #1;
        checks++; if (cif.ready !== 1'b1 || busy !== 1'b0 || cif.err !== 1'b0) begin errors++; $display("FAIL drain_exit: ready %0b busy %0b err %0b exp 1 0 0", cif.ready, busy, cif.err); end
        tick();
        cif.wr_en = 1'b0;
        #1;
        checks++; if (tgt_wr_en !== 3'b001 || tgt_addr !== 6'd9 || tgt_wdata !== d) begin errors++; $display("FAIL stalled_wr: en %0b addr %0d exp 001 9", tgt_wr_en, tgt_addr); end
        exp_mem[key(0, 2, 9)] = d;
        tick();
    endtask

    task automatic test_back_to_back();
        cif.wr_en = 1'b1; cif.bank = {2'd2, 5'd1}; cif.addr = 6'd3; cif.wr_data = rnd_vec();
        s_valid = 1'b1; s_last = 1'b1; m_ready = 1'b1;
        #1;
        checks++; if ({s_ready, m_valid, cif.ready} !== 3'b001) begin errors++; $display("FAIL prio_T: got %03b exp 001", {s_ready, m_valid, cif.ready}); end
        exp_mem[key(2, 1, 3)] = cif.wr_data;
        tick();
        cif.wr_en = 1'b0;
        #1;
        checks++; if (s_ready !== 1'b0 || tgt_wr_en !== 3'b100) begin errors++; $display("FAIL prio_T1: s_ready %0b en %0b exp 0 100", s_ready, tgt_wr_en); end
        tick();
        checks++; if ({s_ready, m_valid, busy} !== 3'b110) begin errors++; $display("FAIL prio_T2: got %03b exp 110", {s_ready, m_valid, busy}); end
        tick();
        s_valid = 1'b0; s_last = 1'b0;
        #1;
        checks++; if (busy !== 1'b1 || s_ready !== 1'b0) begin errors++; $display("FAIL prio_T3: busy %0b s_ready %0b exp 1 0", busy, s_ready); end
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++; if (busy !== 1'b0 || cif.err !== 1'b0) begin errors++; $display("FAIL prio_done: busy %0b err %0b exp 0 0", busy, cif.err); end
    endtask

    task automatic test_done_errors();
        // done on the same cycle as DRAIN entry is spurious.
        s_valid = 1'b1; s_last = 1'b1; m_ready = 1'b1; done = 1'b1;
        tick();
        s_valid = 1'b0; s_last = 1'b0; done = 1'b0;
        #1;
        checks++; if ({cif.err, busy, s_ready} !== 3'b110) begin errors++; $display("FAIL done_drain_entry: got %03b exp 110", {cif.err, busy, s_ready}); end
        tick();
        checks++; if (busy !== 1'b1 || cif.err !== 1'b0) begin errors++; $display("FAIL done_drain_hold: busy %0b err %0b exp 1 0", busy, cif.err); end
        done = 1'b1;
        tick();
        done = 1'b0;
        // done while running is an error and leaves the frame open.
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0; done = 1'b1;
        tick();
        done = 1'b0;
        #1;
        checks++; if ({cif.err, busy, s_ready} !== 3'b111) begin errors++; $display("FAIL done_run: got %03b exp 111", {cif.err, busy, s_ready}); end
        s_valid = 1'b1; s_last = 1'b1;
        tick();
        s_valid = 1'b0; s_last = 1'b0;
        done = 1'b1;
        tick();
        done = 1'b0;
        // Read of out-of-range target: no enable, zero data, normal timing.
        cif.rd_en = 1'b1; cif.bank = {2'd3, 5'd4}; cif.addr = 6'd1;
        tick();
        cif.rd_en = 1'b0;
        #1;
        checks++; if (tgt_rd_en !== 3'b0 || cif.err !== 1'b1) begin errors++; $display("FAIL bad_tgt_T1: en %0b err %0b exp 0 1", tgt_rd_en, cif.err); end
        tick(); tick();
        checks++; if (cif.rd_valid !== 1'b1 || cif.rd_data !== '0) begin errors++; $display("FAIL bad_tgt_T3: valid %0b data %0h exp 1 0", cif.rd_valid, cif.rd_data); end
        tick();
    endtask

    task automatic test_reset_mid();
        do_write(2'd1, 5'd2, 6'd4, rnd_vec());
        cif.rd_en = 1'b1; cif.bank = {2'd1, 5'd2}; cif.addr = 6'd4;
        tick();
        cif.rd_en = 1'b0; rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if ({cif.ready, busy, tgt_rd_en, tgt_wr_en, cif.rd_valid, cif.err} !== 10'b10_0000_0000) begin errors++; $display("FAIL rst_rd_ctrl: got %010b exp 1000000000", {cif.ready, busy, tgt_rd_en, tgt_wr_en, cif.rd_valid, cif.err}); end
        checks++; if (tgt_bank !== '0 || tgt_addr !== '0 || tgt_wdata !== '0 || cif.rd_data !== '0) begin errors++; $display("FAIL rst_rd_bus: bank %0h addr %0h rd_data %0h exp 0", tgt_bank, tgt_addr, cif.rd_data); end
        tick();
        checks++; if (cif.rd_valid !== 1'b0) begin errors++; $display("FAIL rst_rd_discard: got %0b exp 0", cif.rd_valid); end
        s_valid = 1'b1; s_last = 1'b0; m_ready = 1'b1;
        tick();
        s_valid = 1'b0;
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_run_pre: busy %0b exp 1", busy); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if ({busy, cif.ready, s_ready} !== 3'b011) begin errors++; $display("FAIL rst_run: got %03b exp 011", {busy, cif.ready, s_ready}); end
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        cif.rd_en = 1'b0; cif.wr_en = 1'b0; cif.bank = '0; cif.addr = '0; cif.wr_data = '0;
        cif3.rd_en = 1'b0; cif3.wr_en = 1'b0; cif3.bank = '0; cif3.addr = '0; cif3.wr_data = '0;
        s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0; done = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_random_cfg();
        test_stream();
        test_back_to_back();
        test_done_errors();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
